hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
Pipeline control block for the 5-stage ARM-subset pipeline (IF, ID, EX, MEM, WB). It generates PC/IF-ID enables, the control-unit NOP-mux select and the IF/ID flush. It also generates forwarding selects for the PA/PB/PD operand muxes. A debug halt/single-step FSM drains and freezes the pipeline, and saturating counters track stalls and flushes.

Parameters:
DRAIN_CYCLES, 3, bubbles injected after a halt request before halted asserts (1..7)
CNT_W, 16, width of the stall and flush counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
id_ra  in  4  ID source register for PA (instr[3:0])
id_rb  in  4  ID source register for PB (instr[19:16])
id_rd  in  4  ID register for PD (instr[15:12]; store data)
id_ra_use, id_rb_use, id_rd_use  in  1 each  ID instruction reads that operand
ex_rd, mem_rd, wb_rd  in  4 each  destination register in EX/MEM/WB
ex_rf_e, mem_rf_e, wb_rf_e  in  1 each  stage writes the register file
ex_load  in  1  EX instruction is a load
branch_taken  in  1  condition handler Branched (EX)
halt_req  in  1  level; debug requests a halt
step  in  1  one-cycle pulse; advance one instruction while halted
enable_pc  out  1  PC load enable
enable_ifid  out  1  IF/ID load enable
nop_sel  out  1  1 = control-unit mux drives all-zero controls into ID/EX
flush_ifid  out  1  1 = IF/ID loads NOP on next edge
fwd_a, fwd_b, fwd_d  out  2 each  00 RF, 01 EX, 10 MEM, 11 WB
halted  out  1  pipeline drained and frozen
stall_count  out  CNT_W  load-use stall cycles, saturating
flush_count  out  CNT_W  branch flushes, saturating

Behaviour:
- Reset (reset=0, async) state: RUN, drain counter 0, counters 0, halted 0. While in reset: enable_pc=1, enable_ifid=1, nop_sel=0, flush_ifid=0, fwd_*=00.
- Forwarding (combinational, valid in every state):
  - Per operand, priority EX > MEM > WB.
  - EX is eligible only if ex_rf_e & !ex_load. MEM is eligible if mem_rf_e. WB is eligible if wb_rf_e.
  - An operand matches a stage when its *_use=1 and its register equals that stage's rd.
  - Register 15 is never forwarded; it gives 00.
- Load-use hazard (luh, combinational): ex_load & ex_rf_e & ex_rd!=15 & any used ID source equals ex_rd.
- Effect of luh: enable_pc=0, enable_ifid=0, nop_sel=1 in that same cycle; stall_count increments at the edge.
- Effect of branch_taken: flush_ifid=1, nop_sel=1 and enable_pc=1 in that cycle; flush_count increments. branch_taken overrides luh (no stall, no stall count).
- FSM states: RUN, DRAIN, HALTED, STEP.
  - RUN: outputs follow hazards. If halt_req=1, go to DRAIN and load the drain counter with DRAIN_CYCLES.
  - DRAIN: enable_pc=0, enable_ifid=0, nop_sel=1. The counter decrements each cycle; at 1, go to HALTED. halt_req=0 returns to RUN next cycle. branch_taken still asserts flush_ifid and counts.
  - HALTED: halted=1, enable_pc=0, enable_ifid=0, nop_sel=0 (the bubbles are frozen). halt_req=0 goes to RUN. step=1 goes to STEP. If both occur together, halt_req=0 wins.
  - STEP: one cycle with hazard rules as in RUN. If luh is asserted, remain in STEP (the stall consumes the cycle); otherwise go to DRAIN with a reloaded counter.
- Counters saturate at all-ones and are never cleared except by reset.
- Reset asserted mid-operation returns to RUN immediately with all outputs at reset values.

Test Plan:
- Forwarding priority: ID ra=2 used; ex_rd=2 ex_rf_e=1; mem_rd=2 mem_rf_e=1 -> fwd_a=01. Clear ex_rf_e -> fwd_a=10. Set ra=15 -> fwd_a=00.
- Load-use: ex_load=1 ex_rf_e=1 ex_rd=5, id_rb=5 used -> 1 cycle enable_pc=0, enable_ifid=0, nop_sel=1, stall_count 0->1. Next cycle, with the load in MEM, fwd_b=10.
- Branch with luh present: branch_taken=1 with luh=1 -> flush_ifid=1, enable_pc=1, flush_count=1, stall_count unchanged.
- Halt/step: halt_req=1 -> 3 cycles of nop_sel=1 and frozen PC, then halted=1. step pulse -> one cycle enable_pc=1, then 3 drain cycles, then halted=1 again. halt_req=0 -> RUN next cycle.
- Saturation: with CNT_W=4, 20 consecutive luh cycles -> stall_count holds at 15.
- Reset mid-DRAIN: reset=0 asynchronously -> halted=0, enable_pc=1, counters 0. Release reset -> RUN.

Source files
------------

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - 5-stage pipeline hazard, forwarding and debug-halt sequencer
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_ra,
    input  logic [3:0]       id_rb,
    input  logic [3:0]       id_rd,
    input  logic             id_ra_use,
    input  logic             id_rb_use,
    input  logic             id_rd_use,
    input  logic [3:0]       ex_rd,
    input  logic [3:0]       mem_rd,
    input  logic [3:0]       wb_rd,
    input  logic             ex_rf_e,
    input  logic             mem_rf_e,
    input  logic             wb_rf_e,
    input  logic             ex_load,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             step,
    output logic             enable_pc,
    output logic             enable_ifid,
    output logic             nop_sel,
    output logic             flush_ifid,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       fwd_d,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, STEP} state_t;

    state_t     state, state_next;
    logic [2:0] drain_cnt, drain_cnt_next;
    logic       ex_ok, luh;
    logic       pc_c, ifid_c, nop_c, flush_c, halted_c, stall_inc, flush_inc;
    logic [1:0] fa_c, fb_c, fd_c;

    // A load in EX has no data yet, so it is never a forwarding source.
    assign ex_ok = ex_rf_e & ~ex_load;

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src, input logic src_use,
        input logic e_ok, input logic [3:0] e_rd,
        input logic m_ok, input logic [3:0] m_rd,
        input logic w_ok, input logic [3:0] w_rd
    );
        if (!src_use || src == 4'd15) return 2'b00;
        if (e_ok && src == e_rd)      return 2'b01;
        if (m_ok && src == m_rd)      return 2'b10;
        if (w_ok && src == w_rd)      return 2'b11;
        return 2'b00;
    endfunction

    assign fa_c = fwd_sel(id_ra, id_ra_use, ex_ok, ex_rd, mem_rf_e, mem_rd, wb_rf_e, wb_rd);
    assign fb_c = fwd_sel(id_rb, id_rb_use, ex_ok, ex_rd, mem_rf_e, mem_rd, wb_rf_e, wb_rd);
    assign fd_c = fwd_sel(id_rd, id_rd_use, ex_ok, ex_rd, mem_rf_e, mem_rd, wb_rf_e, wb_rd);

    assign luh = ex_load & ex_rf_e & (ex_rd != 4'd15) &
                 ((id_ra_use & (id_ra == ex_rd)) |
                  (id_rb_use & (id_rb == ex_rd)) |
                  (id_rd_use & (id_rd == ex_rd)));

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        pc_c           = 1'b1;
        ifid_c         = 1'b1;
        nop_c          = 1'b0;
        flush_c        = 1'b0;
        halted_c       = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        case (state)
            RUN, STEP: begin
                if (branch_taken) begin
                    flush_c   = 1'b1;
                    nop_c     = 1'b1;
                    flush_inc = 1'b1;
                end else if (luh) begin
                    pc_c      = 1'b0;
                    ifid_c    = 1'b0;
                    nop_c     = 1'b1;
                    stall_inc = 1'b1;
                end
                if (state == RUN) begin
                    if (halt_req) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 3'(DRAIN_CYCLES);
                    end
                end else if (!stall_inc) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 3'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                pc_c   = 1'b0;
                ifid_c = 1'b0;
                nop_c  = 1'b1;
                if (branch_taken) begin
                    flush_c   = 1'b1;
                    flush_inc = 1'b1;
                end
                if (!halt_req) begin
                    state_next = RUN;
                end else if (drain_cnt == 3'd1) begin
                    state_next = HALTED;
                end else begin
                    drain_cnt_next = drain_cnt - 3'd1;
                end
            end
            HALTED: begin
                pc_c     = 1'b0;
                ifid_c   = 1'b0;
                halted_c = 1'b1;
                if (!halt_req)  state_next = RUN;
                else if (step)  state_next = STEP;
            end
            default: state_next = RUN;
        endcase
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign enable_pc   = reset ? pc_c   : 1'b1;
    assign enable_ifid = reset ? ifid_c : 1'b1;
    assign nop_sel     = reset & nop_c;
    assign flush_ifid  = reset & flush_c;
    assign halted      = reset & halted_c;
    assign fwd_a       = reset ? fa_c : 2'b00;
    assign fwd_b       = reset ? fb_c : 2'b00;
    assign fwd_d       = reset ? fd_c : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            drain_cnt   <= 3'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            if (stall_inc && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;
            if (flush_inc && flush_count != {CNT_W{1'b1}})
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
